// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds peripherals, then the 65C02, in reset for fixed intervals.
// Optional macro RESET_SEQ_SOFT_EN adds a soft_rst input that re-resets only the CPU from RUN.
module reset_sequencer #(
  parameter int unsigned PERIPH_CYCLES = 16,
  parameter int unsigned CPU_PHI2      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rst_in,
  input  logic       phi2_en,
`ifdef RESET_SEQ_SOFT_EN
  input  logic       soft_rst,
`endif
  output logic       periph_rst,
  output logic       cpu_resb,
  output logic       ready,
  output logic [1:0] seq_state
);

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    PERIPH = 2'b01,
    CPU    = 2'b10,
    RUN    = 2'b11
  } state_t;

  localparam logic [7:0] PERIPH_LAST = 8'(PERIPH_CYCLES - 1);
  localparam logic [7:0] CPU_LAST    = 8'(CPU_PHI2 - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic       periph_rst_reg;
  logic       cpu_resb_reg;
  logic       ready_reg;
  logic       soft_req;

`ifdef RESET_SEQ_SOFT_EN
  assign soft_req = soft_rst;
`else
  assign soft_req = 1'b0;
`endif

  // Every output is updated on the same edge as the state so no decode sits between flop and pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= HOLD;
      cnt_reg        <= 8'd0;
      periph_rst_reg <= 1'b1;
      cpu_resb_reg   <= 1'b0;
      ready_reg      <= 1'b0;
    end else if (rst_in) begin
      state_reg      <= HOLD;
      cnt_reg        <= 8'd0;
      periph_rst_reg <= 1'b1;
      cpu_resb_reg   <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          state_reg      <= PERIPH;
          cnt_reg        <= 8'd0;
          periph_rst_reg <= 1'b1;
          cpu_resb_reg   <= 1'b0;
          ready_reg      <= 1'b0;
        end
        PERIPH: begin
          if (cnt_reg == PERIPH_LAST) begin
            state_reg      <= CPU;
            cnt_reg        <= 8'd0;
            periph_rst_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        CPU: begin
          // Only PHI2 strobes seen while already in CPU count toward release.
          if (phi2_en) begin
            if (cnt_reg == CPU_LAST) begin
              state_reg    <= RUN;
              cnt_reg      <= 8'd0;
              cpu_resb_reg <= 1'b1;
              ready_reg    <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
        end
        RUN: begin
          if (soft_req) begin
            state_reg    <= CPU;
            cnt_reg      <= 8'd0;
            cpu_resb_reg <= 1'b0;
            ready_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg      <= HOLD;
          cnt_reg        <= 8'd0;
          periph_rst_reg <= 1'b1;
          cpu_resb_reg   <= 1'b0;
          ready_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign periph_rst = periph_rst_reg;
  assign cpu_resb   = cpu_resb_reg;
  assign ready      = ready_reg;
  assign seq_state  = state_reg;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter PERIPH_CYCLES, default 16, clk cycles peripherals stay in reset after rst_in deasserts (legal 1..255).
REQ-002 SHALL have parameter CPU_PHI2, default 8, phi2_en strobes the CPU stays in reset after peripheral release (legal 1..255).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rst_in  input  1  synchronized active-high reset request, clk-domain.
REQ-006 SHALL have port phi2_en  input  1  single-clk strobe marking one 65C02 PHI2 cycle.
REQ-007 SHALL have port periph_rst  output  1  active-high peripheral reset, registered.
REQ-008 SHALL have port cpu_resb  output  1  active-low 65C02 RESB, registered.
REQ-009 SHALL have port ready  output  1  high when sequence complete (state RUN), registered.
REQ-010 SHALL have port seq_state  output  2  current state encoding, debug.

Function
REQ-011 SHALL implement states HOLD=00, PERIPH=01, CPU=10, RUN=11 with one 8-bit counter cnt.
REQ-012 HOLD: periph_rst=1, cpu_resb=0, ready=0; first edge sampling rst_in=0 -> PERIPH, cnt=0.
REQ-013 PERIPH: cnt increments every clk; edge with cnt==PERIPH_CYCLES-1 -> CPU, cnt=0, periph_rst=0 from that edge.
REQ-014 CPU: cnt increments only when phi2_en=1; edge with phi2_en=1 and cnt==CPU_PHI2-1 -> RUN, cpu_resb=1, ready=1 from that edge.
REQ-015 RUN: hold outputs periph_rst=0, cpu_resb=1, ready=1 until rst_in=1.
REQ-016 rst_in=1 in any state SHALL force HOLD at next edge, cnt=0, outputs reasserted that same edge.
REQ-017 rst_in=1 coincident with terminal count SHALL win: HOLD, no transition to CPU/RUN.
REQ-018 phi2_en during HOLD or PERIPH SHALL be ignored; counting not pre-loaded.
REQ-019 Outputs SHALL be glitch-free: driven directly from flops, no combinational decode.
REQ-020 cnt SHALL never wrap; terminal compare stops it before 255.

Reset
REQ-021 reset_n=0 SHALL asynchronously force HOLD, cnt=0, periph_rst=1, cpu_resb=0, ready=0, seq_state=00.
REQ-022 reset_n deassertion SHALL only release flops; sequence starts on first edge with rst_in=0 per REQ-012.
REQ-023 reset_n assertion mid-sequence (any state) SHALL abort immediately to REQ-021 values.

Configuration
REQ-024 Macro RESET_SEQ_SOFT_EN SHALL add input soft_rst (1 bit, synchronous active-high, CPU-only reset request).
REQ-025 With RESET_SEQ_SOFT_EN: soft_rst=1 in RUN -> CPU next edge, cnt=0, cpu_resb=0, ready=0, periph_rst stays 0; ignored in HOLD/PERIPH/CPU; rst_in has priority.
REQ-026 Without RESET_SEQ_SOFT_EN: port soft_rst absent, behaviour identical to soft_rst tied 0.

Verification
REQ-027 reset_n=0 with rst_in=X -> periph_rst=1, cpu_resb=0, ready=0, seq_state=00 without a clock edge.
REQ-028 PERIPH_CYCLES=4, CPU_PHI2=2, phi2_en every 4th clk, rst_in falls -> periph_rst low 5 edges after rst_in first sampled low, cpu_resb/ready high on 2nd phi2_en edge after that.
REQ-029 rst_in pulsed high for 1 clk while in CPU -> HOLD next edge, periph_rst=1, full sequence restarts with same timing as REQ-028.
REQ-030 rst_in=1 on exact edge of PERIPH terminal count -> seq_state=00, periph_rst remains 1.
REQ-031 phi2_en held high continuously during PERIPH -> periph_rst release timing unchanged (4 clks); CPU phase then takes exactly 2 clks.
REQ-032 RESET_SEQ_SOFT_EN defined, soft_rst=1 in RUN -> cpu_resb=0 next edge, periph_rst stays 0, cpu_resb=1 after 2 phi2_en strobes.
